// File: rtl/shift_ctrl_pkg.sv
// Shared types for the shift/load sequencer: FSM state encoding and counter width helper.
// No logic; no latency or flow control of its own.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit index counter width; at least one bit even for degenerate widths.
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mux_dff_stage.sv
// One chain element: enable-gated DFF fed by a load/shift mux, Q <= E ? (L ? R : w) : Q.
// Single-cycle update; holds whenever E is low. Reset comes from the driver forcing E=L=1, R=0.
module mux_dff_stage (
    input  logic clk,
    input  logic w,
    input  logic R,
    input  logic E,
    input  logic L,
    output logic Q
);

    always_ff @(posedge clk) begin
        if (E) begin
            Q <= L ? R : w;
        end
    end

endmodule

// File: rtl/shift_load_ctrl.sv
// Loads a parallel word into a mux+DFF chain on start&ready, then shifts it out MSB first.
// First bit one cycle after acceptance, done pulse after the last bit; pause freezes chain and counter.
module shift_load_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int   WIDTH = 8,
    parameter logic FILL  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    input  logic             pause,
    output logic             q,
    output logic             q_valid,
    output logic             busy,
    output logic             done
);

    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] stage_q;
    logic [WIDTH-1:0] stage_w;
    logic [WIDTH-1:0] stage_r;
    logic             chain_e;
    logic             chain_l;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        chain_e = 1'b0;
        chain_l = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    chain_e = 1'b1;
                    chain_l = 1'b1;
                    count_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!pause) begin
                    chain_e = 1'b1;
                    if (count_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // The stages have no reset pin: a forced load of zero clears them.
        if (reset) begin
            chain_e = 1'b1;
            chain_l = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign stage_r = reset ? '0 : din;
    assign stage_w = {stage_q[WIDTH-2:0], FILL};

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        mux_dff_stage u_stage (
            .clk (clk),
            .w   (stage_w[i]),
            .R   (stage_r[i]),
            .E   (chain_e),
            .L   (chain_l),
            .Q   (stage_q[i])
        );
    end

    assign ready   = (state_q == IDLE);
    assign q_valid = (state_q == SHIFT);
    assign busy    = (state_q == SHIFT) || (state_q == DONE);
    assign done    = (state_q == DONE);
    assign q       = stage_q[WIDTH-1];

endmodule

// File: tb/tb_shift_load_ctrl.sv
// Directed bench for shift_load_ctrl (WIDTH=8, FILL=0); outputs sampled on the falling edge.
module tb_shift_load_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] din;
    logic       ready;
    logic       pause;
    logic       q;
    logic       q_valid;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    shift_load_ctrl #(.WIDTH(8), .FILL(1'b0)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .din     (din),
        .ready   (ready),
        .pause   (pause),
        .q       (q),
        .q_valid (q_valid),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Output vector order: {ready, q, q_valid, busy, done}
    localparam logic [4:0] IDLE_V = 5'b10000;
    localparam logic [4:0] DONE_V = 5'b00011;

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got {rdy,q,qv,busy,done}=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [4:0] bit_v(input logic b);
        return {1'b0, b, 1'b1, 1'b1, 1'b0};
    endfunction

    // Checks eight shifted bits of w (MSB first), then the done cycle and the return to idle.
    task automatic check_word(input string tag, input logic [7:0] w, input logic idle_after);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_bit%0d", tag, i), {ready, q, q_valid, busy, done}, bit_v(w[7-i]));
            step();
        end
        chk({tag, "_done"}, {ready, q, q_valid, busy, done}, DONE_V);
        if (idle_after) begin
            step();
            chk({tag, "_idle"}, {ready, q, q_valid, busy, done}, IDLE_V);
        end
    endtask

    initial begin
        logic [10:0] f0_seq;
        reset = 1'b1;
        start = 1'b0;
        din   = 8'h00;
        pause = 1'b0;

        // 1: two reset cycles, then idle
        step();
        step();
        reset = 1'b0;
        step();
        chk("t1_reset", {ready, q, q_valid, busy, done}, IDLE_V);

        // 2: A5 with no pause
        start = 1'b1;
        din   = 8'hA5;
        step();
        start = 1'b0;
        din   = 8'h00;
        check_word("t2", 8'hA5, 1'b1);

        // 3: F0, pause held for the three cycles starting at the third bit
        f0_seq = 11'b111_1111_0000;
        start  = 1'b1;
        din    = 8'hF0;
        step();
        start  = 1'b0;
        for (int j = 0; j < 11; j++) begin
            chk($sformatf("t3_c%0d", j + 1), {ready, q, q_valid, busy, done}, bit_v(f0_seq[10-j]));
            pause = (j >= 2) && (j <= 4);
            step();
        end
        pause = 1'b0;
        chk("t3_done_k12", {ready, q, q_valid, busy, done}, DONE_V);
        step();
        chk("t3_idle", {ready, q, q_valid, busy, done}, IDLE_V);

        // 4: start stays high with 3C during an A5 transfer
        start = 1'b1;
        din   = 8'hA5;
        step();
        din   = 8'h3C;
        check_word("t4a", 8'hA5, 1'b0);
        step();
        chk("t4_ready_k10", {ready, q, q_valid, busy, done}, IDLE_V);
        step();
        start = 1'b0;
        check_word("t4b", 8'h3C, 1'b1);

        // 5: reset in cycle k+4 of an FF transfer, then 81
        start = 1'b1;
        din   = 8'hFF;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_ff%0d", i), {ready, q, q_valid, busy, done}, bit_v(1'b1));
            if (i == 3) reset = 1'b1;
            step();
        end
        reset = 1'b0;
        chk("t5_after_rst", {ready, q, q_valid, busy, done}, IDLE_V);
        step();
        chk("t5_no_done", {ready, q, q_valid, busy, done}, IDLE_V);
        start = 1'b1;
        din   = 8'h81;
        step();
        start = 1'b0;
        check_word("t5", 8'h81, 1'b1);

        // 6: start and reset together; reset wins
        start = 1'b1;
        reset = 1'b1;
        din   = 8'hFF;
        step();
        start = 1'b0;
        reset = 1'b0;
        chk("t6_rst_wins", {ready, q, q_valid, busy, done}, IDLE_V);
        step();
        chk("t6_still_idle", {ready, q, q_valid, busy, done}, IDLE_V);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
